// File: rtl/load_store_unit_if.sv
// Request/response channel from the execute stage plus the word bus to the data memory.
interface load_store_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_err;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_w_en;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Execute stage and data memory side.
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  mem_addr, mem_w_en, mem_wdata,
        output mem_rdata
    );

    // Load/store unit side.
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output mem_addr, mem_w_en, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, byte/half/word loads with extension,
// sub-word stores as read-modify-write on a whole-word memory, early error reject.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        STORE  = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-3:0] DEPTH_LIMIT = (ADDR_WIDTH-2)'(MEM_DEPTH);

    state_t                state_r;
    state_t                next_state_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [1:0]            size_r;
    logic                  uns_r;
    logic                  err_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic                  size_err_s;
    logic                  range_err_s;
    logic                  req_err_s;
    logic                  accept_s;

    // Pick the addressed lane out of a memory word and sign/zero extend it.
    function automatic logic [DATA_WIDTH-1:0] load_extend(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            size,
        input logic [1:0]            lane,
        input logic                  uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   load_extend = {{24{~uns & b[7]}}, b};
            2'b01:   load_extend = {{16{~uns & h[15]}}, h};
            default: load_extend = word;
        endcase
    endfunction

    // Replace only the addressed lane of the old word with the right-justified store data.
    function automatic logic [DATA_WIDTH-1:0] merge_lane(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [1:0]            size,
        input logic [1:0]            lane
    );
        merge_lane = old_word;
        case (size)
            2'b00: begin
                case (lane)
                    2'b00:   merge_lane[7:0]   = wdata[7:0];
                    2'b01:   merge_lane[15:8]  = wdata[7:0];
                    2'b10:   merge_lane[23:16] = wdata[7:0];
                    default: merge_lane[31:24] = wdata[7:0];
                endcase
            end
            2'b01: begin
                if (lane[1]) begin
                    merge_lane[31:16] = wdata[15:0];
                end else begin
                    merge_lane[15:0] = wdata[15:0];
                end
            end
            default: merge_lane = wdata;
        endcase
    endfunction

    assign range_err_s = (bus.req_addr[ADDR_WIDTH-1:2] >= DEPTH_LIMIT);
    assign req_err_s   = size_err_s | range_err_s;
    assign accept_s    = bus.req_valid & (state_r == IDLE);

    // Size/alignment legality of the incoming request.
    always_comb begin
        size_err_s = 1'b0;
        case (bus.req_size)
            2'b00:   size_err_s = 1'b0;
            2'b01:   size_err_s = bus.req_addr[0];
            2'b10:   size_err_s = (bus.req_addr[1:0] != 2'b00);
            default: size_err_s = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode: errors skip memory entirely, sub-word stores read first.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!bus.req_valid) begin
                    next_state_s = IDLE;
                end else if (req_err_s) begin
                    next_state_s = RESP;
                end else if (!bus.req_we) begin
                    next_state_s = LOAD;
                end else if (bus.req_size == 2'b10) begin
                    next_state_s = STORE;
                end else begin
                    next_state_s = RMW_RD;
                end
            end
            LOAD:    next_state_s = RESP;
            RMW_RD:  next_state_s = STORE;
            STORE:   next_state_s = RESP;
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Request capture, load data extension and store-word assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r  <= {ADDR_WIDTH{1'b0}};
            size_r  <= 2'b00;
            uns_r   <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= {DATA_WIDTH{1'b0}};
            wdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        addr_r  <= bus.req_addr;
                        size_r  <= bus.req_size;
                        uns_r   <= bus.req_unsigned;
                        err_r   <= req_err_s;
                        rdata_r <= {DATA_WIDTH{1'b0}};
                        wdata_r <= (bus.req_we && !req_err_s) ? bus.req_wdata : {DATA_WIDTH{1'b0}};
                    end else begin
                        err_r <= 1'b0;
                    end
                end
                LOAD:    rdata_r <= load_extend(bus.mem_rdata, size_r, addr_r[1:0], uns_r);
                RMW_RD:  wdata_r <= merge_lane(bus.mem_rdata, wdata_r, size_r, addr_r[1:0]);
                STORE:   wdata_r <= {DATA_WIDTH{1'b0}};
                RESP: begin
                    err_r   <= 1'b0;
                    rdata_r <= {DATA_WIDTH{1'b0}};
                end
                default: begin
                    err_r   <= 1'b0;
                    rdata_r <= {DATA_WIDTH{1'b0}};
                    wdata_r <= {DATA_WIDTH{1'b0}};
                end
            endcase
        end
    end

    assign bus.req_ready  = (state_r == IDLE);
    assign bus.resp_valid = (state_r == RESP);
    assign bus.resp_err   = err_r;
    assign bus.resp_rdata = rdata_r;
    assign bus.mem_w_en   = (state_r == STORE);
    assign bus.mem_wdata  = wdata_r;
    assign bus.mem_addr   = ((state_r == LOAD) || (state_r == RMW_RD) || (state_r == STORE))
                          ? {addr_r[ADDR_WIDTH-1:2], 2'b00} : {ADDR_WIDTH{1'b0}};
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, multi-cycle reset/back-to-back
// sequences, and random traffic against a word-array reference model.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    load_store_unit_if bus ();

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, whole-word write on the rising edge.
    logic [31:0] mem [0:1023] = '{default: 32'h0};
    logic [31:0] ref_mem [0:1023] = '{default: 32'h0};
    int wr_count = 0;
    int resp_count = 0;
    int n_checks = 0;
    int n_pass = 0;

    assign bus.mem_rdata = mem[bus.mem_addr[11:2]];

    // Memory write port.
    always @(posedge clk) begin
        if (bus.mem_w_en) mem[bus.mem_addr[11:2]] = bus.mem_wdata;
    end

    // Count write cycles and response pulses mid-cycle.
    always @(negedge clk) begin
        if (bus.mem_w_en) wr_count++;
        if (bus.resp_valid) resp_count++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: what a request should do, computed from byte arithmetic on ref_mem.
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic err, output logic [31:0] rdata, output int lat, output int writes);
        int unsigned word;
        int unsigned sh;
        logic [31:0] v;
        logic [31:0] mask;
        word = addr >> 2;
        sh = 8 * (addr % 4);
        err = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
              (size == 2'd2 && (addr % 4) != 0) || (word >= 1024);
        rdata = 32'h0; lat = 1; writes = 0;
        if (!err) begin
            mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
            if (!we) begin
                v = (ref_mem[word] >> sh) & mask;
                if (!uns && size == 2'd0 && v >= 32'd128)   v = v | 32'hFFFF_FF00;
                if (!uns && size == 2'd1 && v >= 32'd32768) v = v | 32'hFFFF_0000;
                rdata = v; lat = 2;
            end else begin
                ref_mem[word] = (ref_mem[word] & ~(mask << sh)) | ((wdata & mask) << sh);
                lat = (size == 2'd2) ? 2 : 3;
                writes = 1;
            end
        end
    endtask

    // One full transaction: present, wait for accept, time the response, check the pulse.
    task automatic run_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output logic err, output logic [31:0] rdata, output int writes);
        int w0;
        int waitc;
        bit seen;
        logic [31:0] maddr;
        lat = 0; err = 1'b0; rdata = 32'h0; writes = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
        waitc = 0;
        while (!bus.req_ready && waitc < 20) begin @(negedge clk); waitc++; end
        if (!bus.req_ready) begin
            check({tag, "_ready_timeout"}, 32'h0, 32'h1);
            bus.req_valid = 1'b0;
            return;
        end
        w0 = wr_count;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        maddr = bus.mem_addr;
        lat = 1; seen = bus.resp_valid;
        while (!seen && lat < 10) begin @(posedge clk); #1; lat++; seen = bus.resp_valid; end
        if (!seen) begin
            check({tag, "_resp_timeout"}, 32'h0, 32'h1);
            lat = 0;
        end
        err = bus.resp_err; rdata = bus.resp_rdata;
        check({tag, "_mem_addr"}, maddr,
              (seen && lat == 1) ? 32'h0 : {addr[31:2], 2'b00});
        @(negedge clk);
        writes = wr_count - w0;
        @(posedge clk); #1;
        check({tag, "_resp_pulse"}, {31'h0, bus.resp_valid}, 32'h0);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          writes;
    } vec_t;

    vec_t vecs[20];

    initial begin
        int lat, writes, m_lat, m_writes, mism, w0, r0;
        logic err, m_err;
        logic [31:0] rdata, m_rdata;
        logic [31:0] b2b_addr[4];
        logic        b2b_we[4];
        logic [1:0]  b2b_size[4];
        logic [31:0] b2b_wdata[4];
        logic        exp_err_q[$];
        logic [31:0] exp_rd_q[$];
        int acc, rsp, bad_ready;
        bit just_resp, outstanding;

        //          we    size   uns   addr          wdata           err   rdata          lat wr
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        2, 1};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 2, 0};
        vecs[2]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'h11223344, 1'b0, 32'h0,        2, 1};
        vecs[3]  = '{1'b1, 2'd0, 1'b0, 32'h12,  32'hFFFFFFAA, 1'b0, 32'h0,        3, 1};
        vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        1'b0, 32'h11AA3344, 2, 0};
        vecs[5]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'h80FF7F01, 1'b0, 32'h0,        2, 1};
        vecs[6]  = '{1'b0, 2'd0, 1'b0, 32'h12,  32'h0,        1'b0, 32'hFFFFFFFF, 2, 0};
        vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h12,  32'h0,        1'b0, 32'h000080FF, 2, 0};
        vecs[8]  = '{1'b0, 2'd1, 1'b0, 32'h10,  32'h0,        1'b0, 32'h00007F01, 2, 0};
        vecs[9]  = '{1'b1, 2'd1, 1'b0, 32'h11,  32'h5555,     1'b1, 32'h0,        1, 0};
        vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h12,  32'h0,        1'b1, 32'h0,        1, 0};
        vecs[11] = '{1'b0, 2'd3, 1'b0, 32'h10,  32'h0,        1'b1, 32'h0,        1, 0};
        vecs[12] = '{1'b1, 2'd2, 1'b0, 32'h1000, 32'h12345678, 1'b1, 32'h0,       1, 0};
        vecs[13] = '{1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        1'b0, 32'h00000080, 2, 0};
        vecs[14] = '{1'b1, 2'd1, 1'b0, 32'h12,  32'h1234BEEF, 1'b0, 32'h0,        3, 1};
        vecs[15] = '{1'b0, 2'd1, 1'b0, 32'h12,  32'h0,        1'b0, 32'hFFFFBEEF, 2, 0};
        vecs[16] = '{1'b0, 2'd0, 1'b0, 32'h10,  32'h0,        1'b0, 32'h00000001, 2, 0};
        vecs[17] = '{1'b1, 2'd2, 1'b0, 32'hFFC, 32'h12345678, 1'b0, 32'h0,        2, 1};
        vecs[18] = '{1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0,        1'b0, 32'h12345678, 2, 0};
        vecs[19] = '{1'b0, 2'd0, 1'b0, 32'h11,  32'h0,        1'b0, 32'h0000007F, 2, 0};

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready",      {31'h0, bus.req_ready},  32'h1);
        check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        check("rst_resp_err",   {31'h0, bus.resp_err},   32'h0);
        check("rst_resp_rdata", bus.resp_rdata,          32'h0);
        check("rst_mem_addr",   bus.mem_addr,            32'h0);
        check("rst_mem_wdata",  bus.mem_wdata,           32'h0);
        check("rst_mem_w_en",   {31'h0, bus.mem_w_en},   32'h0);
        rst = 1'b0;

        // Directed vectors.
        for (int i = 0; i < 20; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            model(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                  m_err, m_rdata, m_lat, m_writes);
            run_req(t, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                    lat, err, rdata, writes);
            check({t, "_err"},    {31'h0, err},  {31'h0, vecs[i].err});
            check({t, "_rdata"},  rdata,         vecs[i].rdata);
            check({t, "_lat"},    32'(lat),      32'(vecs[i].lat));
            check({t, "_writes"}, 32'(writes),   32'(vecs[i].writes));
        end
        check("vec_mem4", mem[4], 32'hBEEF7F01);

        // Reset while in RMW_RD: no write, no response, IDLE next cycle.
        run_req("pre12", 1'b1, 2'd2, 1'b0, 32'h30, 32'hA5A5A5A5, lat, err, rdata, writes);
        model(1'b1, 2'd2, 1'b0, 32'h30, 32'hA5A5A5A5, m_err, m_rdata, m_lat, m_writes);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
        bus.req_addr = 32'h31; bus.req_wdata = 32'h3C;
        w0 = wr_count; r0 = resp_count;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rmw_rst_ready", {31'h0, bus.req_ready}, 32'h1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rmw_rst_nowrite", 32'(wr_count - w0),   32'h0);
        check("rmw_rst_noresp",  32'(resp_count - r0), 32'h0);
        check("rmw_rst_mem",     mem[12],              32'hA5A5A5A5);

        // Reset while in STORE: the write still lands, no response follows.
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
        bus.req_addr = 32'h34; bus.req_wdata = 32'h0BADF00D;
        w0 = wr_count; r0 = resp_count;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model(1'b1, 2'd2, 1'b0, 32'h34, 32'h0BADF00D, m_err, m_rdata, m_lat, m_writes);
        check("st_rst_ready", {31'h0, bus.req_ready}, 32'h1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("st_rst_write",  32'(wr_count - w0),   32'h1);
        check("st_rst_noresp", 32'(resp_count - r0), 32'h0);
        check("st_rst_mem",    mem[13],              32'h0BADF00D);

        // Back-to-back: req_valid held high across four requests.
        b2b_we[0] = 1'b1; b2b_size[0] = 2'd2; b2b_addr[0] = 32'h20; b2b_wdata[0] = 32'hCAFEF00D;
        b2b_we[1] = 1'b0; b2b_size[1] = 2'd2; b2b_addr[1] = 32'h20; b2b_wdata[1] = 32'h0;
        b2b_we[2] = 1'b1; b2b_size[2] = 2'd0; b2b_addr[2] = 32'h21; b2b_wdata[2] = 32'h5A;
        b2b_we[3] = 1'b0; b2b_size[3] = 2'd2; b2b_addr[3] = 32'h20; b2b_wdata[3] = 32'h0;
        acc = 0; rsp = 0; bad_ready = 0; just_resp = 0; outstanding = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_unsigned = 1'b0;
        bus.req_we = b2b_we[0]; bus.req_size = b2b_size[0];
        bus.req_addr = b2b_addr[0]; bus.req_wdata = b2b_wdata[0];
        for (int cyc = 0; cyc < 60 && rsp < 4; cyc++) begin
            if (bus.resp_valid) begin
                if (exp_rd_q.size() == 0) begin
                    check("b2b_extra_resp", 32'h1, 32'h0);
                end else begin
                    check($sformatf("b2b_rdata%0d", rsp), bus.resp_rdata, exp_rd_q.pop_front());
                    check($sformatf("b2b_err%0d", rsp), {31'h0, bus.resp_err},
                          {31'h0, exp_err_q.pop_front()});
                end
                rsp++; outstanding = 0; just_resp = 1;
            end else if (just_resp) begin
                if (!bus.req_ready) bad_ready++;
                just_resp = 0;
            end else begin
                if (outstanding && bus.req_ready) bad_ready++;
            end
            if (bus.req_valid && bus.req_ready) begin
                model(bus.req_we, bus.req_size, bus.req_unsigned, bus.req_addr, bus.req_wdata,
                      m_err, m_rdata, m_lat, m_writes);
                exp_rd_q.push_back(m_rdata);
                exp_err_q.push_back(m_err);
                acc++; outstanding = 1;
                @(negedge clk);
                if (acc < 4) begin
                    bus.req_we = b2b_we[acc]; bus.req_size = b2b_size[acc];
                    bus.req_addr = b2b_addr[acc]; bus.req_wdata = b2b_wdata[acc];
                end else begin
                    bus.req_valid = 1'b0;
                end
            end else begin
                @(negedge clk);
            end
        end
        bus.req_valid = 1'b0;
        check("b2b_accepts",  32'(acc),       32'h4);
        check("b2b_resps",    32'(rsp),       32'h4);
        check("b2b_ready",    32'(bad_ready), 32'h0);
        check("b2b_mem8",     mem[8],         32'hCAFE5A0D);

        // Random traffic against the reference model.
        for (int i = 0; i < 150; i++) begin
            logic        r_we, r_uns;
            logic [1:0]  r_size;
            logic [31:0] r_addr, r_wdata;
            r_we    = 1'($urandom_range(0, 1));
            r_uns   = 1'($urandom_range(0, 1));
            r_size  = 2'($urandom_range(0, 3));
            r_wdata = $urandom;
            r_addr  = ($urandom_range(0, 7) == 0) ? 32'h1000 + 32'($urandom_range(0, 255))
                                                 : 32'($urandom_range(0, 63));
            model(r_we, r_size, r_uns, r_addr, r_wdata, m_err, m_rdata, m_lat, m_writes);
            run_req("rnd", r_we, r_size, r_uns, r_addr, r_wdata, lat, err, rdata, writes);
            check("rnd_err",    {31'h0, err}, {31'h0, m_err});
            check("rnd_rdata",  rdata,        m_rdata);
            check("rnd_lat",    32'(lat),     32'(m_lat));
            check("rnd_writes", 32'(writes),  32'(m_writes));
        end

        mism = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mism++;
        check("final_mem", 32'(mism), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
